regfile_wr_arbiter: RTL and testbench

// - Shares the single write port of the 16x32 register file between two writeback sources:
//   A = ALU result, B = load/memory result.
// - Per-source valid/ready handshake; round-robin grant; one registered write stage.
// - Forwarding outputs cover the cycle in which a granted write is not yet visible on the file's reads.
// - Sits between the pipeline writeback stage and reg_file.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_wr_arbiter_rr_arb2.sv | 59 +++++
 rtl/regfile_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_pkg                                                      |
// | Purpose  : Shared widths, register count and grant encoding for the        |
// |            register-file write arbiter and its round-robin sub-arbiter.    |
// | Contents : ADDR_W, DATA_W, NUM_REGS, grant_t, other_grant()                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package regfile_pkg;

  localparam int ADDR_W   = 4;   // register address width
  localparam int DATA_W   = 32;  // register data width
  localparam int NUM_REGS = 16;  // registers in the file

  // Identifies which writeback source owns a grant.
  typedef enum logic {
    GNT_A = 1'b0,  // ALU result
    GNT_B = 1'b1   // load / memory result
  } grant_t;

  // The source that did not receive grant g.
  function automatic grant_t other_grant(input grant_t g);
    return (g == GNT_A) ? GNT_B : GNT_A;
  endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arb2                                                         |
// | Purpose  : Two-way round-robin arbiter. Picks a winner combinationally     |
// |            from the request vector; remembers the last winner so that a    |
// |            standing conflict alternates between the two requesters.        |
// | Ports    : clk, reset     - clock, synchronous active-high reset           |
// |            req[1:0]       - bit 0 = source A request, bit 1 = source B     |
// |            advance        - the current grant was consumed this cycle      |
// |            grant          - winning source (meaningful when grant_valid)   |
// |            grant_valid    - at least one request is present                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output grant_t     grant,
  output logic       grant_valid
);

  grant_t last_grant_q;
  grant_t last_grant_d;

  always_comb begin
    grant       = GNT_A;
    grant_valid = |req;
    case (req)
      2'b01:   grant = GNT_A;
      2'b10:   grant = GNT_B;
      // Conflict: whoever did not win last time goes now.
      2'b11:   grant = other_grant(last_grant_q);
      default: grant = GNT_A;
    endcase
  end

  // History only moves when a grant is actually consumed, so a source that
  // is held off by back-pressure keeps its priority.
  always_comb begin
    last_grant_d = last_grant_q;
    if (advance) begin
      last_grant_d = grant;
    end
  end

  // Reset to B so that A wins the first conflict after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GNT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_wr_arbiter                                              |
// | Purpose  : Shares the single write port of the 16x32 register file         |
// |            between the ALU writeback (A) and the load writeback (B).       |
// |            One registered write stage; round-robin grant; forwarding of    |
// |            the staged value while it is not yet visible on file reads.     |
// | Ports    : clk, reset                 - clock, sync active-high reset      |
// |            a_valid/a_ready/a_addr/a_data - source A handshake + payload    |
// |            b_valid/b_ready/b_addr/b_data - source B handshake + payload    |
// |            wr_block                   - hold the stage, no file write      |
// |            rf_wr_en/rf_write_addr/rf_write_data - reg_file write port      |
// |            rd_addr1/rd_addr2          - copies of the file read addresses  |
// |            fwd_hit1/2, fwd_data1/2    - staged value overrides file reads  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module regfile_wr_arbiter
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,

  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,

  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,

  input  logic              wr_block,

  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,

  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
);

  // ---------------------------------------------------------------------------
  // Write stage state
  // ---------------------------------------------------------------------------
  logic              stg_valid_q;
  logic              stg_valid_d;
  logic [ADDR_W-1:0] stg_addr_q;
  logic [ADDR_W-1:0] stg_addr_d;
  logic [DATA_W-1:0] stg_data_q;
  logic [DATA_W-1:0] stg_data_d;

  // ---------------------------------------------------------------------------
  // Handshake / arbitration
  // ---------------------------------------------------------------------------
  grant_t w_grant;
  logic   w_grant_valid;
  logic   w_space;
  logic   w_a_take;
  logic   w_b_take;
  logic   w_xfer;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .reset       (reset),
    .req         ({b_valid, a_valid}),
    .advance     (w_xfer),
    .grant       (w_grant),
    .grant_valid (w_grant_valid)
  );

  // The stage can take a new write if it is empty, or if its current
  // contents are leaving for the file this very cycle.
  assign w_space = !stg_valid_q || !wr_block;

  // A grant only exists when its source is requesting, so ready can never
  // rise without the matching valid. Reset suppresses both readies.
  assign w_a_take = !reset && w_space && w_grant_valid && (w_grant == GNT_A);
  assign w_b_take = !reset && w_space && w_grant_valid && (w_grant == GNT_B);
  assign w_xfer   = w_a_take || w_b_take;

  assign a_ready = w_a_take;
  assign b_ready = w_b_take;

  // ---------------------------------------------------------------------------
  // Stage next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    stg_valid_d = stg_valid_q;
    stg_addr_d  = stg_addr_q;
    stg_data_d  = stg_data_q;
    if (w_xfer) begin
      // Covers both fill-from-empty and drain-plus-refill in one cycle.
      stg_valid_d = 1'b1;
      stg_addr_d  = w_a_take ? a_addr : b_addr;
      stg_data_d  = w_a_take ? a_data : b_data;
    end else if (!wr_block) begin
      // Contents (if any) go to the file this cycle; nothing replaces them.
      stg_valid_d = 1'b0;
    end
  end

  // Reset drops any staged write: it never reaches the file.
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid_q <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register-file write port
  // ---------------------------------------------------------------------------
  assign rf_wr_en      = !reset && stg_valid_q && !wr_block;
  assign rf_write_addr = stg_addr_q;
  assign rf_write_data = stg_data_q;

  // ---------------------------------------------------------------------------
  // Forwarding: the staged write is newer than anything the file returns.
  // Deliberately independent of wr_block - a blocked stage is still newer.
  // ---------------------------------------------------------------------------
  assign fwd_hit1  = !reset && stg_valid_q && (stg_addr_q == rd_addr1);
  assign fwd_hit2  = !reset && stg_valid_q && (stg_addr_q == rd_addr2);
  assign fwd_data1 = stg_data_q;
  assign fwd_data2 = stg_data_q;

endmodule : regfile_wr_arbiter
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_regfile_wr_arbiter                                           |
// | Purpose  : Self-checking bench for regfile_wr_arbiter. Stimulus drives      |
// |            directed scenarios then random traffic; a behavioural model     |
// |            predicts handshakes, forwarding and file contents; a monitor    |
// |            pops expected writes from a scoreboard queue.                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              a_valid, a_ready, b_valid, b_ready, wr_block;
  logic [ADDR_W-1:0] a_addr, b_addr, rf_write_addr, rd_addr1, rd_addr2;
  logic [DATA_W-1:0] a_data, b_data, rf_write_data, fwd_data1, fwd_data2;
  logic              rf_wr_en, fwd_hit1, fwd_hit2;

  regfile_wr_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_addr        (a_addr),
    .a_data        (a_data),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .b_addr        (b_addr),
    .b_data        (b_data),
    .wr_block      (wr_block),
    .rf_wr_en      (rf_wr_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .fwd_hit1      (fwd_hit1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t         exp_q[$];          // writes the file should see, in order
  int          wr_log[$];         // addresses actually written by the DUT
  logic [31:0] m_file[NUM_REGS];  // model register file
  logic [31:0] dut_file[NUM_REGS];// file rebuilt from DUT write port

  // Model: one pending write (or none) plus who won the last grant.
  bit          m_pend;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  int          m_last;            // 0 = A won last, 1 = B won last

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then
  // advance the model to the state after the following posedge.
  task automatic cycle(input bit rst, input bit av, input logic [3:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [3:0] ba, input logic [31:0] bd,
                       input bit blk, input logic [3:0] r1, input logic [3:0] r2);
    bit space, ea, eb, ewr, h1, h2;
    int win;
    @(negedge clk);
    reset = rst; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    wr_block = blk; rd_addr1 = r1; rd_addr2 = r2;
    #2;
    space = !m_pend || !blk;
    win = -1;
    if (av && bv)  win = (m_last == 1) ? 0 : 1;
    else if (av)   win = 0;
    else if (bv)   win = 1;
    ea  = !rst && space && (win == 0);
    eb  = !rst && space && (win == 1);
    ewr = !rst && m_pend && !blk;
    h1  = !rst && m_pend && (m_addr == r1);
    h2  = !rst && m_pend && (m_addr == r2);
    chk("a_ready",  a_ready,  ea);
    chk("b_ready",  b_ready,  eb);
    chk("rf_wr_en", rf_wr_en, ewr);
    chk("fwd_hit1", fwd_hit1, h1);
    chk("fwd_hit2", fwd_hit2, h2);
    if (h1) chk("fwd_data1", fwd_data1, m_data);
    if (h2) chk("fwd_data2", fwd_data2, m_data);
    if (rst) begin
      m_pend = 1'b0;
      m_last = 1;
      exp_q.delete();
    end else begin
      if (ewr) m_file[m_addr] = m_data;
      if (ea || eb) begin
        m_pend = 1'b1;
        m_addr = ea ? aa : ba;
        m_data = ea ? ad : bd;
        m_last = win;
        exp_q.push_back('{m_addr, m_data});
      end else if (!blk) begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: whenever the DUT writes the file, the oldest expected write
  // must match it.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rf_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual_addr=%0h required=no_write", rf_write_addr);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {28'd0, rf_write_addr}, {28'd0, e.addr});
          chk("wr_data", rf_write_data, e.data);
        end
        dut_file[rf_write_addr] = rf_write_data;
        wr_log.push_back(int'(rf_write_addr));
      end
    end
  end

  initial begin : stim
    bit          rst, av, bv, blk;
    logic [3:0]  aa, ba, r1, r2;
    logic [31:0] ad, bd;

    reset = 1'b1; a_valid = 0; b_valid = 0; wr_block = 0;
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0; rd_addr1 = 0; rd_addr2 = 0;
    m_pend = 0; m_addr = 0; m_data = 0; m_last = 1;
    for (int i = 0; i < NUM_REGS; i++) begin
      m_file[i]   = 32'd0;
      dut_file[i] = 32'd0;
    end

    // Reset: requests present but nothing may be accepted or written.
    cycle(1, 1, 4'd1, 32'h1, 1, 4'd2, 32'h2, 0, 0, 0);
    cycle(1, 1, 4'd1, 32'h1, 1, 4'd2, 32'h2, 0, 0, 0);
    chk("reset_a_ready", a_ready, 1'b0);

    // A alone: accepted, written next cycle, in the file afterwards.
    cycle(0, 1, 4'd3, 32'hDEAD, 0, 0, 0, 0, 0, 0);
    chk("a_alone_ready", a_ready, 1'b1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 4'd3, 0);
    chk("a_alone_wr_addr", {28'd0, rf_write_addr}, 32'd3);
    idle(1);
    chk("file_r3", dut_file[3], 32'hDEAD);

    // Both valid for 4 cycles after reset: A,B,A,B.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wr_log.delete();
    for (int i = 0; i < 4; i++) cycle(0, 1, 4'd1, 32'h11, 1, 4'd2, 32'h22, 0, 0, 0);
    idle(2);
    chk("rr_count", wr_log.size(), 32'd4);
    if (wr_log.size() == 4) begin
      chk("rr_seq0", wr_log[0], 32'd1);
      chk("rr_seq1", wr_log[1], 32'd2);
      chk("rr_seq2", wr_log[2], 32'd1);
      chk("rr_seq3", wr_log[3], 32'd2);
    end

    // wr_block with a full stage: held for 3 cycles, then drain + accept.
    cycle(0, 1, 4'd8, 32'h88, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 4'd9, 32'h99, 0, 0, 0, 1, 0, 0);
      chk("blk_a_ready", a_ready, 1'b0);
    end
    cycle(0, 1, 4'd9, 32'h99, 0, 0, 0, 0, 0, 0);
    chk("unblk_a_ready", a_ready, 1'b1);
    idle(2);
    chk("file_r8", dut_file[8], 32'h88);
    chk("file_r9", dut_file[9], 32'h99);

    // Forwarding from a held stage.
    cycle(0, 1, 4'd5, 32'h55, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 4'd5, 4'd6);
    chk("fwd5_hit1",  fwd_hit1,  1'b1);
    chk("fwd5_data1", fwd_data1, 32'h55);
    chk("fwd6_hit2",  fwd_hit2,  1'b0);
    idle(2);

    // Same address, after reset (A wins first): B's value is last.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 4'd7, 32'hA, 1, 4'd7, 32'hB, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 4'd7, 32'hB, 0, 0, 0);
    idle(2);
    chk("same_addr_r7_b_last", dut_file[7], 32'hB);
    // Now A won last, so B goes first and A's value is last.
    cycle(0, 1, 4'd0, 32'h1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 4'd7, 32'hA, 1, 4'd7, 32'hB, 0, 0, 0);
    chk("same_addr_b_first", b_ready, 1'b1);
    cycle(0, 1, 4'd7, 32'hA, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("same_addr_r7_a_last", dut_file[7], 32'hA);

    // Reset while the stage holds r4: the write is dropped.
    cycle(0, 1, 4'd4, 32'h44, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 4'd4, 0);
    chk("rst_drop_wr_en", rf_wr_en, 1'b0);
    idle(3);
    chk("file_r4_untouched", dut_file[4], 32'h0);
    cycle(0, 1, 4'd10, 32'hAA, 1, 4'd11, 32'hBB, 0, 0, 0);
    chk("post_rst_a_wins", a_ready, 1'b1);
    chk("post_rst_b_waits", b_ready, 1'b0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(99) == 0);
      av  = ($urandom_range(9) < 6);
      bv  = ($urandom_range(9) < 6);
      blk = ($urandom_range(3) == 0);
      aa  = 4'($urandom_range(15));
      ba  = 4'($urandom_range(15));
      ad  = $urandom;
      bd  = $urandom;
      r1  = $urandom_range(1) ? m_addr : 4'($urandom_range(15));
      r2  = $urandom_range(1) ? m_addr : 4'($urandom_range(15));
      cycle(rst, av, aa, ad, bv, ba, bd, blk, r1, r2);
    end

    idle(3);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    for (int i = 0; i < NUM_REGS; i++) chk($sformatf("file_r%0d", i), dut_file[i], m_file[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_wr_arbiter
`default_nettype wire
